// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the timing source and the
// pixel-colour stage.
package vga_pkg;

  // Default 640x480@60 timing, pixel clock derived from a 100 MHz system clock
  localparam int DEF_ACTIVE_HORI      = 640;
  localparam int DEF_FRONT_PORCH_HORI = 16;
  localparam int DEF_SYNC_PULSE_HORI  = 96;
  localparam int DEF_BACK_PORCH_HORI  = 48;
  localparam int DEF_ACTIVE_VERT      = 480;
  localparam int DEF_FRONT_PORCH_VERT = 10;
  localparam int DEF_SYNC_PULSE_VERT  = 2;
  localparam int DEF_BACK_PORCH_VERT  = 33;
  localparam int DEF_PERIOD_COUNT     = 4;
  localparam int DEF_SYNC_ACTIVE_LOW  = 1;

  // Position counters are 10 bits wide, so a line or frame holds at most 1024
  localparam int COUNT_W   = 10;
  localparam int MAX_TOTAL = 1024;

  // Total length of a line or frame from its four timing segments
  function automatic int timing_total(input int active, input int front_porch,
                                      input int sync_pulse, input int back_porch);
    return active + front_porch + sync_pulse + back_porch;
  endfunction

  // Pin level for a sync signal given whether it is logically asserted
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return active_low ? ~asserted : asserted;
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Clock divider producing a one-clk pixel tick every PERIOD_COUNT clocks.
module vga_pixel_tick #(
  parameter int PERIOD_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic enable
);

  localparam int DIV_W = (PERIOD_COUNT > 1) ? $clog2(PERIOD_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD_COUNT - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             enable_q, enable_d;

  // Next divider value; the tick is registered so it is high exactly while
  // the divider sits at its last value. Stopping clears the divider.
  always_comb begin
    div_d    = '0;
    enable_d = 1'b0;
    if (run) begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      enable_d = (div_d == DIV_LAST);
    end
  end

  // Divider and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      enable_q <= enable_d;
    end
  end

  assign enable = enable_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel tick, h/v position counters and registered
// sync/active/frame_start decode aligned with the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int ACTIVE_HORI      = DEF_ACTIVE_HORI,
  parameter int FRONT_PORCH_HORI = DEF_FRONT_PORCH_HORI,
  parameter int SYNC_PULSE_HORI  = DEF_SYNC_PULSE_HORI,
  parameter int BACK_PORCH_HORI  = DEF_BACK_PORCH_HORI,
  parameter int ACTIVE_VERT      = DEF_ACTIVE_VERT,
  parameter int FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
  parameter int SYNC_PULSE_VERT  = DEF_SYNC_PULSE_VERT,
  parameter int BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT,
  parameter int PERIOD_COUNT     = DEF_PERIOD_COUNT,
  parameter int SYNC_ACTIVE_LOW  = DEF_SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               enable,
  output logic [COUNT_W-1:0] h_count,
  output logic [COUNT_W-1:0] v_count,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               active,
  output logic               frame_start
);

  localparam int H_TOTAL = timing_total(ACTIVE_HORI, FRONT_PORCH_HORI,
                                        SYNC_PULSE_HORI, BACK_PORCH_HORI);
  localparam int V_TOTAL = timing_total(ACTIVE_VERT, FRONT_PORCH_VERT,
                                        SYNC_PULSE_VERT, BACK_PORCH_VERT);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || PERIOD_COUNT < 1) begin : g_bad_params
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and PERIOD_COUNT >= 1");
    end
  endgenerate

  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_ACT    = COUNT_W'(ACTIVE_HORI);
  localparam logic [COUNT_W-1:0] V_ACT    = COUNT_W'(ACTIVE_VERT);
  localparam logic [COUNT_W-1:0] HS_FIRST = COUNT_W'(ACTIVE_HORI + FRONT_PORCH_HORI);
  localparam logic [COUNT_W-1:0] HS_LAST  = COUNT_W'(ACTIVE_HORI + FRONT_PORCH_HORI
                                                     + SYNC_PULSE_HORI - 1);
  localparam logic [COUNT_W-1:0] VS_FIRST = COUNT_W'(ACTIVE_VERT + FRONT_PORCH_VERT);
  localparam logic [COUNT_W-1:0] VS_LAST  = COUNT_W'(ACTIVE_VERT + FRONT_PORCH_VERT
                                                     + SYNC_PULSE_VERT - 1);
  localparam logic SYNC_LOW  = (SYNC_ACTIVE_LOW != 0);
  localparam logic SYNC_IDLE = SYNC_LOW;

  logic               tick;
  logic [COUNT_W-1:0] h_q, h_d, v_q, v_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               active_q, active_d, frame_start_q, frame_start_d;

  vga_pixel_tick #(
    .PERIOD_COUNT (PERIOD_COUNT)
  ) u_pixel_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .enable (tick)
  );

  // Advance position on each pixel tick; decode flags from the next position
  // so the registered flags always describe the registered counters.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + COUNT_W'(1);
      end else begin
        h_d = h_q + COUNT_W'(1);
      end
      hsync_d       = sync_level((h_d >= HS_FIRST) && (h_d <= HS_LAST), SYNC_LOW);
      vsync_d       = sync_level((v_d >= VS_FIRST) && (v_d <= VS_LAST), SYNC_LOW);
      active_d      = (h_d < H_ACT) && (v_d < V_ACT);
      frame_start_d = (h_d == '0) && (v_d == '0);
    end
  end

  // Position and decoded-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign enable      = tick;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing at PERIOD_COUNT=4
// (instance a) and a short-frame, active-high, PERIOD_COUNT=1 variant (b).
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_a_n, run_a, rst_b_n, run_b;
  logic       en_a, hs_a, vs_a, act_a, fs_a;
  logic       en_b, hs_b, vs_b, act_b, fs_b;
  logic [9:0] h_a, v_a, h_b, v_b;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk (clk), .rst_n (rst_a_n), .run (run_a), .enable (en_a),
    .h_count (h_a), .v_count (v_a), .HSYNC (hs_a), .VSYNC (vs_a),
    .active (act_a), .frame_start (fs_a)
  );

  vga_timing_gen #(
    .ACTIVE_VERT (6), .FRONT_PORCH_VERT (2), .SYNC_PULSE_VERT (2),
    .BACK_PORCH_VERT (2), .PERIOD_COUNT (1), .SYNC_ACTIVE_LOW (0)
  ) dut_b (
    .clk (clk), .rst_n (rst_b_n), .run (run_b), .enable (en_b),
    .h_count (h_b), .v_count (v_b), .HSYNC (hs_b), .VSYNC (vs_b),
    .active (act_b), .frame_start (fs_b)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Wait for the next pixel tick of instance a, then step past the edge that
  // consumes it so the counters have advanced.
  task automatic tick_a();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (en_a !== 1'b1 && n < 16);
    if (en_a !== 1'b1) check("tick_a_timeout", int'(en_a), 1);
    @(posedge clk); #1;
  endtask

  // Model of the default-timing position (800 x 525)
  int eh, ev;
  task automatic adv_a();
    if (eh == 799) begin
      eh = 0;
      ev = (ev == 524) ? 0 : ev + 1;
    end else eh++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pos_err, hs_err, fl_err, hs_low, first_low, last_low, en_err, hold_err;
    int ebh, ebv, b_err_pos, b_err_hs, b_err_vs, b_err_act, b_err_en;
    int hs_hi, vs_hi, fs_cnt, fs_first, fs_second, act_acc, act_frame;

    rst_a_n = 1'b0; run_a = 1'b0; rst_b_n = 1'b0; run_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, both polarities
    check("a_rst_enable", int'(en_a), 0);
    check("a_rst_h", int'(h_a), 0);
    check("a_rst_v", int'(v_a), 0);
    check("a_rst_hsync", int'(hs_a), 1);
    check("a_rst_vsync", int'(vs_a), 1);
    check("a_rst_active", int'(act_a), 0);
    check("a_rst_fs", int'(fs_a), 0);
    check("b_rst_hsync", int'(hs_b), 0);
    check("b_rst_vsync", int'(vs_b), 0);

    // Release and run: tick high after edges 3,7,11; first count on edge 4
    rst_a_n = 1'b1; run_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("a_enable_clk%0d", k), int'(en_a), (k % 4 == 3) ? 1 : 0);
      if (k == 3) begin
        check("a_h_before_update", int'(h_a), 0);
        check("a_active_before_update", int'(act_a), 0);
        check("a_hsync_before_update", int'(hs_a), 1);
      end
      if (k == 4) begin
        check("a_h_first_update", int'(h_a), 1);
        check("a_active_first_update", int'(act_a), 1);
      end
    end
    check("a_h_after_12clk", int'(h_a), 3);
    eh = 3; ev = 0;

    // Full line: track every tick up to (0,1)
    pos_err = 0; hs_err = 0; fl_err = 0; hs_low = 0; first_low = -1; last_low = -1;
    for (int i = 0; i < 1000 && !(eh == 0 && ev == 1); i++) begin
      tick_a();
      adv_a();
      if (h_a !== 10'(eh) || v_a !== 10'(ev)) pos_err++;
      if (hs_a !== ((eh >= 656 && eh <= 751) ? 1'b0 : 1'b1)) hs_err++;
      if (vs_a !== 1'b1 || fs_a !== 1'b0) fl_err++;
      if (act_a !== ((eh < 640 && ev < 480) ? 1'b1 : 1'b0)) fl_err++;
      if (hs_a === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(h_a);
        last_low = int'(h_a);
      end
    end
    check("a_line_pos_errors", pos_err, 0);
    check("a_line_hsync_errors", hs_err, 0);
    check("a_line_flag_errors", fl_err, 0);
    check("a_hsync_low_ticks", hs_low, 96);
    check("a_hsync_first_low_h", first_low, 656);
    check("a_hsync_last_low_h", last_low, 751);
    check("a_wrap_h", int'(h_a), 0);
    check("a_wrap_v", int'(v_a), 1);

    // Advance to h=300 then freeze for 100 clks
    pos_err = 0;
    for (int i = 0; i < 1000 && eh != 300; i++) begin
      tick_a();
      adv_a();
      if (h_a !== 10'(eh) || v_a !== 10'(ev)) pos_err++;
    end
    check("a_to300_pos_errors", pos_err, 0);
    run_a = 1'b0;
    en_err = 0; hold_err = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (en_a !== 1'b0) en_err++;
      if (h_a !== 10'd300 || v_a !== 10'd1) hold_err++;
    end
    check("a_pause_enable_errors", en_err, 0);
    check("a_pause_hold_errors", hold_err, 0);
    run_a = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("a_resume_enable_clk3", int'(en_a), 1);
    check("a_resume_h_clk3", int'(h_a), 300);
    @(posedge clk); #1;
    check("a_resume_h_clk4", int'(h_a), 301);
    eh = 301;

    // Advance to h=700 (inside sync) then reset asynchronously
    pos_err = 0;
    for (int i = 0; i < 1000 && eh != 700; i++) begin
      tick_a();
      adv_a();
      if (h_a !== 10'(eh) || v_a !== 10'(ev)) pos_err++;
    end
    check("a_to700_pos_errors", pos_err, 0);
    check("a_hsync_at700", int'(hs_a), 0);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("a_async_rst_h", int'(h_a), 0);
    check("a_async_rst_v", int'(v_a), 0);
    check("a_async_rst_hsync", int'(hs_a), 1);
    check("a_async_rst_enable", int'(en_a), 0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("a_restart_h", int'(h_a), 1);
    check("a_restart_v", int'(v_a), 0);

    // Variant b: 800 x 12 frame, sync v=8..9, active 640 x 6, tick every clk
    rst_b_n = 1'b1; run_b = 1'b1;
    @(posedge clk); #1;
    check("b_enable_first_clk", int'(en_b), 1);
    check("b_h_first_clk", int'(h_b), 0);
    check("b_active_first_clk", int'(act_b), 0);
    ebh = 0; ebv = 0;
    b_err_pos = 0; b_err_hs = 0; b_err_vs = 0; b_err_act = 0; b_err_en = 0;
    hs_hi = 0; vs_hi = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    act_acc = 0; act_frame = -1;
    for (int n = 1; n <= 19300; n++) begin
      @(posedge clk); #1;
      if (ebh == 799) begin
        ebh = 0;
        ebv = (ebv == 11) ? 0 : ebv + 1;
      end else ebh++;
      if (h_b !== 10'(ebh) || v_b !== 10'(ebv)) b_err_pos++;
      if (hs_b !== ((ebh >= 656 && ebh <= 751) ? 1'b1 : 1'b0)) b_err_hs++;
      if (vs_b !== ((ebv >= 8 && ebv <= 9) ? 1'b1 : 1'b0)) b_err_vs++;
      if (act_b !== ((ebh < 640 && ebv < 6) ? 1'b1 : 1'b0)) b_err_act++;
      if (en_b !== 1'b1) b_err_en++;
      if (hs_b === 1'b1) hs_hi++;
      if (vs_b === 1'b1) vs_hi++;
      if (fs_b === 1'b1) begin
        if (fs_cnt == 0) fs_first = n;
        if (fs_cnt == 1) begin
          fs_second = n;
          act_frame = act_acc;
        end
        fs_cnt++;
        act_acc = 0;
      end
      if (act_b === 1'b1) act_acc++;
    end
    check("b_pos_errors", b_err_pos, 0);
    check("b_hsync_errors", b_err_hs, 0);
    check("b_vsync_errors", b_err_vs, 0);
    check("b_active_errors", b_err_act, 0);
    check("b_enable_not_constant", b_err_en, 0);
    check("b_hsync_high_clks", hs_hi, 24 * 96);
    check("b_vsync_high_clks", vs_hi, 2 * 1600);
    check("b_frame_start_count", fs_cnt, 2);
    check("b_frame_start_first", fs_first, 9600);
    check("b_frame_start_period", fs_second - fs_first, 9600);
    check("b_active_per_frame", act_frame, 640 * 6);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
             n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
